// File: rtl/req_arbiter_8.sv
// Registered 8-way arbiter with fixed-priority or round-robin selection
// and a bounded grant hold time with forced release.
module req_arbiter_8 #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       mode,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state, state_d;
    logic [2:0]          last_id, last_d;
    logic [HOLD_W-1:0]   hold_cnt, hold_d;
    logic [7:0]          gnt_d;
    logic                gnt_valid_d, timeout_d;
    logic [2:0]          start, idx, win;
    logic                found;

    // Descending search from start; round robin puts the last winner last.
    always_comb begin
        start = mode ? last_id - 3'd1 : 3'd7;
        idx   = start;
        win   = start;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = start - 3'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_id   <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_d;
            last_id   <= last_d;
            hold_cnt  <= hold_d;
            gnt       <= gnt_d;
            gnt_valid <= gnt_valid_d;
            timeout   <= timeout_d;
        end
    end

    always_comb begin
        state_d = state;
        last_d  = last_id;
        hold_d  = hold_cnt;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    last_d  = win;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (!req[last_id]) begin
                    state_d = IDLE;
                end else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_valid_d = (state_d == GRANT);
        gnt_d       = gnt_valid_d ? (8'b1 << last_d) : 8'b0;
        timeout_d   = (state == GRANT) && (state_d == IDLE) && req[last_id];
    end

    assign gnt_id = last_id;

endmodule

// File: tb/tb_req_arbiter_8.sv
// Scoreboard bench for req_arbiter_8 against a cycle-level
// behavioural model of the arbitration rules.
module tb_req_arbiter_8;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       mode = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    req_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] g;
        logic [2:0] id;
        logic       v;
        logic       to;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;

    int owner = -1;
    int held  = 0;
    int last  = 0;
    bit to_m  = 1'b0;

    function automatic int pick(input logic [7:0] r, input bit m);
        int s;
        s = m ? (last + 7) % 8 : 7;
        for (int k = 0; k < 8; k++) begin
            int i;
            i = (s - k + 8) % 8;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        owner = -1;
        held  = 0;
        last  = 0;
        to_m  = 1'b0;
    endtask

    task automatic step(input logic [7:0] r, input bit m);
        int w;
        exp_t x;
        @(negedge clk);
        req  = r;
        mode = m;
        if (owner < 0) begin
            to_m = 1'b0;
            w = pick(r, m);
            if (w >= 0) begin
                owner = w;
                last  = w;
                held  = 1;
            end
        end else if (!r[owner]) begin
            owner = -1;
            to_m  = 1'b0;
        end else if (held == MAX_HOLD) begin
            owner = -1;
            to_m  = 1'b1;
        end else begin
            held++;
        end
        x.g  = (owner < 0) ? 8'h00 : 8'(1 << owner);
        x.id = 3'(last);
        x.v  = (owner >= 0);
        x.to = to_m;
        sbq.push_back(x);
    endtask

    task automatic chk_idle(input string name);
        checks++;
        if (gnt === 8'h00 && gnt_valid === 1'b0 && timeout === 1'b0
            && gnt_id === 3'd0)
            passed++;
        else
            $display("FAIL %s: gnt=%h id=%0d v=%b to=%b, want 00/0/0/0",
                     name, gnt, gnt_id, gnt_valid, timeout);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("async_reset");
        model_reset();
        req = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (gnt === e.g && gnt_id === e.id && gnt_valid === e.v
                && timeout === e.to)
                passed++;
            else
                $display("FAIL cyc%0d: gnt=%h id=%0d v=%b to=%b, want %h/%0d/%b/%b",
                         cyc, gnt, gnt_id, gnt_valid, timeout,
                         e.g, e.id, e.v, e.to);
        end
    end

    initial begin
        logic [7:0] r;
        bit m;
        int len;

        req  = 8'hFF;
        mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset_hold");
        @(negedge clk);
        req   = 8'h00;
        rst_n = 1'b1;

        step(8'h24, 0);
        step(8'h00, 0);
        step(8'h00, 0);
        repeat (3) step(8'h04, 0);
        repeat (2) step(8'h00, 0);
        repeat (40) step(8'h80, 0);
        step(8'h00, 0);
        step(8'h00, 1);
        repeat (60) step(8'hFF, 1);
        repeat (30) step(8'h81, 1);
        repeat (3) step(8'h81, 0);
        repeat (20) step(8'h81, 0);
        step(8'h00, 0);
        repeat (6) step(8'h10, 0);
        reset_pulse();
        repeat (22) step(8'h10, 1);

        for (int s = 0; s < 80; s++) begin
            r   = ($urandom % 3 == 0) ? 8'($urandom & $urandom) : 8'($urandom);
            m   = 1'($urandom);
            len = $urandom_range(1, 40);
            for (int c = 0; c < len; c++) begin
                if ($urandom % 8 == 0) r ^= 8'(1 << ($urandom % 8));
                if ($urandom % 16 == 0) m = ~m;
                step(r, m);
            end
            if ($urandom % 4 == 0) step(8'h00, m);
            if (s == 40) reset_pulse();
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sbq.size() == 0)
            passed++;
        else
            $display("FAIL drain: %0d entries left, want 0", sbq.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
